// File: rtl/swizzle_dram_to_cram.sv
// Fetches row-major DRAM words and writes them bit-transposed to a CRAM port through ping/pong bit buffers.
// Optional feature macro SWIZZLE_D2C_DMA_MODE_EN adds a dma_mode input for straight-through word copies.
module swizzle_dram_to_cram #(
   parameter int DWIDTH     = 40,
   parameter int MEM_AWIDTH = 16,
   parameter int RAM_AWIDTH = 9,
   parameter int NBLK_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  start,
   input  logic [NBLK_WIDTH-1:0] num_blocks,
   input  logic [MEM_AWIDTH-1:0] mem_ctrl_addr_start,
   input  logic [RAM_AWIDTH-1:0] ram_addr_start,
`ifdef SWIZZLE_D2C_DMA_MODE_EN
   input  logic                  dma_mode,
`endif
   output logic                  mem_ctrl_re,
   input  logic                  mem_ctrl_ready,
   output logic [MEM_AWIDTH-1:0] mem_ctrl_addr,
   input  logic                  mem_ctrl_rvalid,
   input  logic [DWIDTH-1:0]     mem_ctrl_data_in,
   output logic                  ram_we,
   output logic [RAM_AWIDTH-1:0] ram_addr,
   output logic [DWIDTH-1:0]     ram_data_out,
   output logic                  ram_data_last,
   output logic                  busy,
   output logic                  done
);

   localparam int CW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
   localparam int IW = $clog2(DWIDTH + 1);
   localparam int OW = IW + 1;
   localparam logic [CW-1:0] LAST_IDX  = CW'(DWIDTH - 1);
   localparam logic [IW-1:0] FULL_CNT  = IW'(DWIDTH);
   localparam logic [IW-1:0] LAST_ISS  = IW'(DWIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
   typedef enum logic [1:0] {B_EMPTY, B_FILL, B_FULL, B_DRAIN} buf_state_t;

   state_t                state, state_n;
   buf_state_t            buf_st [2];
   buf_state_t            buf_n  [2];
   logic [DWIDTH-1:0]     bufs   [2][DWIDTH];

   logic [NBLK_WIDTH-1:0] nblk, nblk_last;
   logic [NBLK_WIDTH-1:0] blk_issue, blk_drain;
   logic                  fill_sel;
   logic [IW-1:0]         issue_cnt;
   logic [CW-1:0]         row_cnt;
   logic [OW-1:0]         outstanding;
   logic                  drain_active, drain_active_n;
   logic                  drain_sel, drain_sel_n;
   logic [CW-1:0]         col_cnt, col_n;
   logic [DWIDTH-1:0]     col_word;

   logic                  xfer_active, handshake, rvalid_acc;
   logic                  fill_done, drain_end, last_issue;

   logic                  dma_q, dma_we, dma_last;
   logic [DWIDTH-1:0]     dma_data;

   assign nblk_last   = nblk - NBLK_WIDTH'(1);
   assign xfer_active = (state == RUN) || (state == FLUSH);
   assign handshake   = mem_ctrl_re && mem_ctrl_ready;
   // In DMA mode blk_issue/blk_drain count words issued/received instead of blocks.
   assign rvalid_acc  = xfer_active && mem_ctrl_rvalid &&
                        (dma_q ? (blk_drain != blk_issue) : (outstanding != '0));
   assign fill_done   = rvalid_acc && !dma_q && (row_cnt == LAST_IDX);
   assign drain_end   = drain_active && (col_cnt == LAST_IDX);
   assign last_issue  = handshake && (blk_issue == nblk_last) &&
                        (dma_q || (issue_cnt == LAST_ISS));

   always_comb begin
      mem_ctrl_re = 1'b0;
      if (state == RUN) begin
         if (dma_q) begin
            mem_ctrl_re = 1'b1;
         end else begin
            mem_ctrl_re = (issue_cnt < FULL_CNT) &&
                          ((buf_st[fill_sel] == B_EMPTY) || (buf_st[fill_sel] == B_FILL));
         end
      end
   end

   always_comb begin
      col_word = '0;
      for (int i = 0; i < DWIDTH; i++) begin
         col_word[i] = bufs[drain_sel][i][col_cnt];
      end
   end

   assign ram_we        = dma_q ? dma_we : drain_active;
   assign ram_data_out  = dma_q ? dma_data : (drain_active ? col_word : '0);
   assign ram_data_last = dma_q ? dma_last : (drain_end && (blk_drain == nblk_last));
   assign busy          = (state != IDLE);
   assign done          = (state == DONE);

   // Buffer hand-off and drain scheduling; a buffer filled this cycle may start draining next cycle.
   always_comb begin
      state_n        = state;
      buf_n[0]       = buf_st[0];
      buf_n[1]       = buf_st[1];
      drain_active_n = drain_active;
      drain_sel_n    = drain_sel;
      col_n          = col_cnt;

      if (handshake && !dma_q && (buf_st[fill_sel] == B_EMPTY)) begin
         buf_n[fill_sel] = B_FILL;
      end
      if (drain_active) begin
         col_n = col_cnt + 1'b1;
      end
      if (drain_end) begin
         buf_n[drain_sel] = B_EMPTY;
         drain_active_n   = 1'b0;
         col_n            = '0;
      end
      if (fill_done) begin
         buf_n[fill_sel] = B_FULL;
      end
      if (!drain_active || drain_end) begin
         if (buf_n[0] == B_FULL) begin
            buf_n[0]       = B_DRAIN;
            drain_active_n = 1'b1;
            drain_sel_n    = 1'b0;
            col_n          = '0;
         end else if (buf_n[1] == B_FULL) begin
            buf_n[1]       = B_DRAIN;
            drain_active_n = 1'b1;
            drain_sel_n    = 1'b1;
            col_n          = '0;
         end
      end

      case (state)
         IDLE: begin
            if (start) begin
               state_n = (num_blocks == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (last_issue) begin
               state_n = FLUSH;
            end
         end
         FLUSH: begin
            if (dma_q) begin
               if (dma_we && dma_last) begin
                  state_n = DONE;
               end
            end else if ((outstanding == '0) && (buf_n[0] == B_EMPTY) &&
                         (buf_n[1] == B_EMPTY) && !drain_active_n) begin
               state_n = DONE;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         buf_st[0]     <= B_EMPTY;
         buf_st[1]     <= B_EMPTY;
         drain_active  <= 1'b0;
         drain_sel     <= 1'b0;
         col_cnt       <= '0;
         fill_sel      <= 1'b0;
         nblk          <= '0;
         blk_issue     <= '0;
         blk_drain     <= '0;
         issue_cnt     <= '0;
         row_cnt       <= '0;
         outstanding   <= '0;
         mem_ctrl_addr <= '0;
         ram_addr      <= '0;
      end else begin
         buf_st[0]    <= buf_n[0];
         buf_st[1]    <= buf_n[1];
         drain_active <= drain_active_n;
         drain_sel    <= drain_sel_n;
         col_cnt      <= col_n;
         if ((state == IDLE) && start) begin
            nblk          <= num_blocks;
            mem_ctrl_addr <= mem_ctrl_addr_start;
            ram_addr      <= ram_addr_start;
            blk_issue     <= '0;
            blk_drain     <= '0;
            issue_cnt     <= '0;
            row_cnt       <= '0;
            outstanding   <= '0;
         end else begin
            if (handshake) begin
               mem_ctrl_addr <= mem_ctrl_addr + 1'b1;
            end
            if (ram_we) begin
               ram_addr <= ram_addr + 1'b1;
            end
            if (handshake && (dma_q || (issue_cnt == LAST_ISS))) begin
               blk_issue <= blk_issue + 1'b1;
            end
            if (dma_q ? rvalid_acc : drain_end) begin
               blk_drain <= blk_drain + 1'b1;
            end
            if (fill_done) begin
               issue_cnt <= '0;
               row_cnt   <= '0;
               fill_sel  <= ~fill_sel;
            end else begin
               if (handshake && !dma_q) begin
                  issue_cnt <= issue_cnt + 1'b1;
               end
               if (rvalid_acc && !dma_q) begin
                  row_cnt <= row_cnt + 1'b1;
               end
            end
            if (!dma_q) begin
               outstanding <= outstanding + OW'(handshake) - OW'(rvalid_acc);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rvalid_acc && !dma_q) begin
         bufs[fill_sel][row_cnt] <= mem_ctrl_data_in;
      end
   end

`ifdef SWIZZLE_D2C_DMA_MODE_EN
   always_ff @(posedge clk) begin
      if (!resetn) begin
         dma_q    <= 1'b0;
         dma_we   <= 1'b0;
         dma_last <= 1'b0;
         dma_data <= '0;
      end else begin
         if ((state == IDLE) && start) begin
            dma_q <= dma_mode;
         end
         dma_we   <= rvalid_acc && dma_q;
         dma_last <= rvalid_acc && dma_q && (blk_drain == nblk_last);
         dma_data <= mem_ctrl_data_in;
      end
   end
`else
   assign dma_q    = 1'b0;
   assign dma_we   = 1'b0;
   assign dma_last = 1'b0;
   assign dma_data = '0;
`endif

endmodule

// File: tb/tb_swizzle_dram_to_cram.sv
// Directed bench for swizzle_dram_to_cram at DWIDTH=8 with a 2-cycle-latency memory model.
// The DMA-mode step is built only when SWIZZLE_D2C_DMA_MODE_EN is defined.
module tb_swizzle_dram_to_cram;

   localparam int DW  = 8;
   localparam int MAW = 16;
   localparam int RAW = 9;
   localparam int NBW = 8;

   logic           clk = 1'b0;
   logic           resetn = 1'b0;
   logic           start = 1'b0;
   logic [NBW-1:0] num_blocks = '0;
   logic [MAW-1:0] mem_ctrl_addr_start = '0;
   logic [RAW-1:0] ram_addr_start = '0;
`ifdef SWIZZLE_D2C_DMA_MODE_EN
   logic           dma_mode = 1'b0;
`endif
   logic           mem_ctrl_re;
   logic           mem_ctrl_ready = 1'b0;
   logic [MAW-1:0] mem_ctrl_addr;
   logic           mem_ctrl_rvalid = 1'b0;
   logic [DW-1:0]  mem_ctrl_data_in = '0;
   logic           ram_we;
   logic [RAW-1:0] ram_addr;
   logic [DW-1:0]  ram_data_out;
   logic           ram_data_last;
   logic           busy;
   logic           done;

   always #5 clk = ~clk;

   swizzle_dram_to_cram #(.DWIDTH(DW), .MEM_AWIDTH(MAW), .RAM_AWIDTH(RAW), .NBLK_WIDTH(NBW)) dut (
      .clk(clk), .resetn(resetn), .start(start), .num_blocks(num_blocks),
      .mem_ctrl_addr_start(mem_ctrl_addr_start), .ram_addr_start(ram_addr_start),
`ifdef SWIZZLE_D2C_DMA_MODE_EN
      .dma_mode(dma_mode),
`endif
      .mem_ctrl_re(mem_ctrl_re), .mem_ctrl_ready(mem_ctrl_ready), .mem_ctrl_addr(mem_ctrl_addr),
      .mem_ctrl_rvalid(mem_ctrl_rvalid), .mem_ctrl_data_in(mem_ctrl_data_in),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_data_out(ram_data_out),
      .ram_data_last(ram_data_last), .busy(busy), .done(done));

   logic [DW-1:0] mem [256];
   logic          ready_toggle = 1'b0;
   logic          p1_v = 1'b0;
   logic [DW-1:0] p1_d = '0;
   int            cyc = 0;

   // Memory model: data returns exactly two cycles after the accepting edge.
   always @(posedge clk) begin
      cyc              <= cyc + 1;
      mem_ctrl_ready   <= ready_toggle ? ~mem_ctrl_ready : 1'b1;
      p1_v             <= mem_ctrl_re && mem_ctrl_ready;
      p1_d             <= mem[mem_ctrl_addr[7:0]];
      mem_ctrl_rvalid  <= p1_v;
      mem_ctrl_data_in <= p1_d;
   end

   logic [MAW-1:0] iss_q [$];
   logic [RAW-1:0] wa_q  [$];
   logic [DW-1:0]  wd_q  [$];
   logic           wl_q  [$];
   int             wc_q  [$];
   int             rv_q  [$];
   int             done_cnt = 0, done_cyc = 0, re_cnt = 0;
   int             clr_req = 0, clr_seen = 0;

   always @(negedge clk) begin
      if (clr_req != clr_seen) begin
         clr_seen = clr_req;
         iss_q.delete(); wa_q.delete(); wd_q.delete(); wl_q.delete();
         wc_q.delete(); rv_q.delete();
         done_cnt = 0; done_cyc = 0; re_cnt = 0;
      end
      if (mem_ctrl_re) re_cnt++;
      if (mem_ctrl_re && mem_ctrl_ready) iss_q.push_back(mem_ctrl_addr);
      if (mem_ctrl_rvalid) rv_q.push_back(cyc);
      if (ram_we) begin
         wa_q.push_back(ram_addr); wd_q.push_back(ram_data_out);
         wl_q.push_back(ram_data_last); wc_q.push_back(cyc);
      end
      if (done) begin
         done_cnt++; done_cyc = cyc;
      end
   end

   int checks = 0;
   int errors = 0;
   int start_cyc = 0;

   // Hand-computed transposes of words 0x20..0x37, three 8-word blocks.
   logic [7:0] exp_t [24] = '{8'hAA, 8'hCC, 8'hF0, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00,
                              8'hAA, 8'hCC, 8'hF0, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00,
                              8'hAA, 8'hCC, 8'hF0, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00};

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic clear_logs();
      clr_req++;
      @(negedge clk); #1;
   endtask

   task automatic apply_stimulus(input int nb, input logic [MAW-1:0] maddr, input logic [RAW-1:0] raddr,
                                 input logic dma);
      @(posedge clk); #1;
      start = 1'b1;
      num_blocks = NBW'(nb);
      mem_ctrl_addr_start = maddr;
      ram_addr_start = raddr;
`ifdef SWIZZLE_D2C_DMA_MODE_EN
      dma_mode = dma;
`else
      if (dma) $display("[TB] dma step requested without DMA build");
`endif
      start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 600 && done_cnt == 0; i++) @(posedge clk);
      repeat (3) @(posedge clk);
      check_output({tag, "_done_once"}, done_cnt, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      @(negedge clk);
      check_output({tag, "_re"}, mem_ctrl_re, 0);
      check_output({tag, "_maddr"}, mem_ctrl_addr, 0);
      check_output({tag, "_we"}, ram_we, 0);
      check_output({tag, "_raddr"}, ram_addr, 0);
      check_output({tag, "_rdata"}, ram_data_out, 0);
      check_output({tag, "_last"}, ram_data_last, 0);
      check_output({tag, "_busy"}, busy, 0);
      check_output({tag, "_done"}, done, 0);
   endtask

   // mode 0: identity pattern 1<<(c%8); mode 1: exp_t table; mode 2: words 0x40+c
   task automatic check_writes(input string tag, input int n, input int mode, input logic [RAW-1:0] raddr);
      logic [7:0]     e;
      logic [RAW-1:0] ea;
      check_output({tag, "_nwrites"}, wd_q.size(), n);
      for (int c = 0; c < n; c++) begin
         e = 8'h01;
         if (mode == 0) e = e << (c % 8);
         else if (mode == 1) e = exp_t[c];
         else e = 8'h40 + 8'(c);
         ea = raddr + RAW'(c);
         check_output($sformatf("%s_data%0d", tag, c), wd_q[c], e);
         check_output($sformatf("%s_addr%0d", tag, c), wa_q[c], ea);
         check_output($sformatf("%s_last%0d", tag, c), wl_q[c], (c == n - 1) ? 1 : 0);
      end
      check_output({tag, "_done_after_last"}, done_cyc, wc_q[n-1] + 1);
   endtask

   task automatic check_issues(input string tag, input int n, input logic [MAW-1:0] base);
      logic [MAW-1:0] ea;
      check_output({tag, "_nissues"}, iss_q.size(), n);
      for (int k = 0; k < n; k++) begin
         ea = base + MAW'(k);
         check_output($sformatf("%s_iss%0d", tag, k), iss_q[k], ea);
      end
   endtask

   initial begin
      for (int a = 0; a < 256; a++) mem[a] = 8'(a);
      for (int i = 0; i < 8; i++) mem[8'h10 + i] = 8'h01 << i;

      repeat (3) @(posedge clk);
      check_reset_outputs("por");
      @(posedge clk); #1 resetn = 1'b1;

      // single block, identity transpose, latency and busy
      clear_logs();
      apply_stimulus(1, 16'h0010, 9'h000, 1'b0);
      @(negedge clk);
      check_output("t1_busy", busy, 1);
      wait_done("t1");
      check_writes("t1", 8, 0, 9'h000);
      check_issues("t1", 8, 16'h0010);
      check_output("t1_first_we_lat", wc_q[0], rv_q[7] + 1);
      check_output("t1_busy_after", busy, 0);

      // three blocks with CRAM address wrap
      clear_logs();
      apply_stimulus(3, 16'h0020, 9'h1F0, 1'b0);
      wait_done("t2");
      check_writes("t2", 24, 1, 9'h1F0);
      check_issues("t2", 24, 16'h0020);

      // ready toggling with DRAM address wrap, same data as blocks 0 and 1 above
      for (int k = 0; k < 16; k++) mem[8'hF8 + 8'(k)] = 8'h20 + 8'(k);
      ready_toggle = 1'b1;
      clear_logs();
      apply_stimulus(2, 16'hFFF8, 9'h005, 1'b0);
      wait_done("t3");
      check_writes("t3", 16, 1, 9'h005);
      check_issues("t3", 16, 16'hFFF8);
      ready_toggle = 1'b0;

      // zero blocks
      clear_logs();
      apply_stimulus(0, 16'h0030, 9'h000, 1'b0);
      wait_done("t4");
      check_output("t4_done_cycle", done_cyc, start_cyc + 1);
      check_output("t4_no_re", re_cnt, 0);
      check_output("t4_no_we", wd_q.size(), 0);

      // reset in the middle of block 1 of 3, then a clean single-block transfer
      clear_logs();
      apply_stimulus(3, 16'h0020, 9'h000, 1'b0);
      for (int i = 0; i < 400 && wd_q.size() < 10; i++) @(posedge clk);
      check_output("t5_progress", (wd_q.size() >= 10) ? 1 : 0, 1);
      @(posedge clk); #1 resetn = 1'b0;
      @(posedge clk); #1 resetn = 1'b1;
      check_reset_outputs("t5_rst");
      repeat (3) @(posedge clk);
      clear_logs();
      apply_stimulus(1, 16'h0010, 9'h040, 1'b0);
      wait_done("t5");
      check_writes("t5", 8, 0, 9'h040);

`ifdef SWIZZLE_D2C_DMA_MODE_EN
      // straight-through copy of five words
      clear_logs();
      apply_stimulus(5, 16'h0040, 9'h100, 1'b1);
      wait_done("t6");
      check_writes("t6", 5, 2, 9'h100);
      dma_mode = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
